// File: rtl/display_arbiter.sv
// display_arbiter: time-shares one 4-digit seven-segment driver between four
// requesters (0 = halt/exception, 1 = CPU MMIO, 2 = PC probe, 3 = cycle count).
// Round-robin ownership with a minimum dwell per owner and a forced blanking
// gap on every owner change. Outputs decode only registered state/owner, plus
// the owner's live data slice.
// Optional feature macro: DISPLAY_ARB_PREEMPT_EN -- requester 0 preempts any
// other owner in SHOW regardless of dwell.
module display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] data,
  output logic [3:0]  grant,
  output logic        disp_on,
  output logic [15:0] disp_number,
  output logic        busy
);

  localparam int unsigned NREQ   = 4;
  localparam int unsigned IDXW   = 2;
  localparam int unsigned DW     = 16;
  localparam int unsigned DWELLW = 16;
  localparam int unsigned BLANKW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   owner, owner_nxt;
  logic [IDXW-1:0]   last, last_nxt;
  logic [DWELLW-1:0] dwell_cnt, dwell_nxt;
  logic [BLANKW-1:0] blank_cnt, blank_nxt;

  logic [IDXW-1:0]   winner;
  logic              winner_vld;
  logic [IDXW-1:0]   scan_idx;
  logic [NREQ-1:0]   others;
  logic              preempt;
  logic              dwell_done;
  logic              blank_done;

`ifdef DISPLAY_ARB_PREEMPT_EN
  assign preempt = (owner != IDXW'(0)) && req[0];
`else
  assign preempt = 1'b0;
`endif

  assign others     = req & ~(NREQ'(1) << owner);
  assign dwell_done = (dwell_cnt == DWELLW'(DWELL_CYCLES - 1));
  assign blank_done = (blank_cnt == BLANKW'(BLANK_CYCLES - 1));

  // Round-robin winner: first set req at or after last+1, wrapping.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = last + IDXW'(k);
      if (!winner_vld && req[scan_idx]) begin
        winner     = scan_idx;
        winner_vld = 1'b1;
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      last      <= IDXW'(NREQ - 1);
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      dwell_cnt <= dwell_nxt;
      blank_cnt <= blank_nxt;
    end
  end

  // Next-state: ownership hand-off, blanking and dwell accounting.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    dwell_nxt = dwell_cnt;
    blank_nxt = blank_cnt;
    case (state)
      ST_IDLE: begin
        if (req != '0) begin
          state_nxt = ST_BLANK;
          owner_nxt = winner;
          blank_nxt = '0;
        end
      end
      ST_BLANK: begin
        if (blank_done) begin
          state_nxt = ST_SHOW;
          last_nxt  = owner;
          dwell_nxt = '0;
        end else begin
          blank_nxt = blank_cnt + BLANKW'(1);
        end
      end
      ST_SHOW: begin
        dwell_nxt = dwell_cnt + DWELLW'(1);
        if (preempt) begin
          state_nxt = ST_BLANK;
          owner_nxt = '0;
          blank_nxt = '0;
        end else if (!req[owner]) begin
          // Owner released: hand over if anyone waits, otherwise idle.
          if (req != '0) begin
            state_nxt = ST_BLANK;
            owner_nxt = winner;
            blank_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (dwell_done) begin
          // Dwell over: rotate if contended, else keep showing without a blank.
          if (others != '0) begin
            state_nxt = ST_BLANK;
            owner_nxt = winner;
            blank_nxt = '0;
          end else begin
            dwell_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and owner.
  always_comb begin
    grant       = '0;
    disp_on     = 1'b0;
    disp_number = '0;
    busy        = (state != ST_IDLE);
    if (state == ST_SHOW) begin
      grant       = NREQ'(1) << owner;
      disp_on     = 1'b1;
      disp_number = data[DW*owner +: DW];
    end
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
Shares the single 4-digit seven-segment display driver between four requesters: halt/exception status, CPU MMIO display register, PC debug probe and cycle counter. The arbitration is round-robin with a minimum dwell time per owner and a blanking gap on every owner change. The block drives the display driver's on/number inputs and returns a one-hot grant to the requesters. It sits between the core/debug logic and the display multiplexer.

Parameters:
DWELL_CYCLES, 1000, minimum SHOW cycles per grant before a pending requester may take over; legal range 1..65535.
BLANK_CYCLES, 4, cycles the display is forced off between owners; legal range 1..255.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  4  per-requester display request, level; index 0 = halt/exception
data  input  64  requester values; requester i occupies bits [16i+15:16i]
grant  output  4  one-hot, asserted for the owner only while in SHOW
disp_on  output  1  to display driver "on"; 1 only in SHOW
disp_number  output  16  to display driver "number"; live data slice of owner in SHOW, else 0
busy  output  1  1 in BLANK or SHOW

Behaviour:
- Reset: state IDLE, owner=0, last=3, dwell/blank counters=0; grant=0, disp_on=0, disp_number=0, busy=0. Reset is asynchronous and forces these values immediately, including mid-SHOW or mid-BLANK.
- Outputs are decoded from registered state/owner only; no combinational path from req to grant.
- Winner selection: scan req from index (last+1) mod 4 upward, wrapping; the first set bit wins.
- IDLE: if req!=0 at cycle t, then at t+1 latch owner=winner, set blank counter=0, go to BLANK.
- BLANK: disp_on=0 and grant=0. The blank counter increments each cycle. When counter==BLANK_CYCLES-1, go to SHOW, set last=owner and dwell counter=0. The first SHOW cycle is t+1+BLANK_CYCLES.
- BLANK with owner's req dropped: the owner is still served; re-evaluation happens in SHOW.
- SHOW: grant[owner]=1, disp_on=1, disp_number=data[owner] (live, not latched). The dwell counter increments each cycle.
- Owner drops req in SHOW:
  - If other requests are pending, go next cycle to BLANK with a new winner.
  - Otherwise go to IDLE.
  - This applies regardless of the dwell count.
- Dwell expiry (counter==DWELL_CYCLES-1) with owner still requesting:
  - If another req is pending, go to BLANK with the winner. The scan starts at owner+1, so others win before the owner.
  - If only the owner is requesting, stay in SHOW, reset the dwell counter to 0, and do not blank.
- Owner drop and dwell expiry in the same cycle: treat as a drop.
- req changes in BLANK do not change the latched owner.

Optional Feature:
Macro: DISPLAY_ARB_PREEMPT_EN.
- Defined: in SHOW with owner!=0, req[0]=1 forces BLANK next cycle with owner=0, ignoring the dwell count. Requester 0 is never preempted. last updates normally.
- Undefined: requester 0 has no special priority and participates only in round-robin.

Test Plan:
1. DWELL=8, BLANK=4; req=0001, data0=16'h1234 from cycle 0 -> disp_on=0 cycles 1-4; cycle 5 grant=0001, disp_on=1, disp_number=1234, busy=1.
2. req=0011 held, data0=16'h1111, data1=16'h2222 -> owners alternate 0,1,0,1. Each SHOW lasts 8 cycles, separated by 4 blank cycles.
3. req=0010 only; drop req1 on the 3rd SHOW cycle -> next cycle IDLE, grant=0, disp_number=0, busy=0.
4. req=1111 held -> grant sequence 0001,0010,0100,1000,0001. Each SHOW lasts 8 cycles; a single owner alone never blanks.
5. Assert reset during SHOW of owner 2 -> grant=0, disp_on=0 immediately. After release, req=0100 -> owner 2 is served after 4 blank cycles.
6. With the macro defined: owner 2 in SHOW cycle 1, req0 rises -> BLANK next cycle, then grant=0001. Without the macro: owner 2 keeps the display until dwell expiry.
